// File: rtl/ascon_ise_seq_if.sv
// Front-end state handshake plus the ISE ALU request/response port of the Ascon linear-layer sequencer.
// slave = the sequencer's view, master = the environment driving it.
interface ascon_ise_seq_if;
   logic         s_valid;
   logic         s_ready;
   logic [319:0] s_state;
   logic         m_valid;
   logic         m_ready;
   logic [319:0] m_state;
   logic         m_err;
   logic [4:0]   ise_fn;
   logic [6:0]   ise_imm;
   logic [31:0]  ise_in1;
   logic [31:0]  ise_in2;
   logic         ise_val;
   logic         ise_oval;
   logic [31:0]  ise_out;

   modport slave (
      input  s_valid, s_state, m_ready, ise_oval, ise_out,
      output s_ready, m_valid, m_state, m_err, ise_fn, ise_imm, ise_in1, ise_in2, ise_val
   );

   modport master (
      output s_valid, s_state, m_ready, ise_oval, ise_out,
      input  s_ready, m_valid, m_state, m_err, ise_fn, ise_imm, ise_in1, ise_in2, ise_val
   );
endinterface

// File: rtl/ascon_ise_seq.sv
// Ascon linear layer over 320-bit state via 10 sigma_lo/hi ISE ops; ASCON_SEQ_WDOG_EN adds a stall watchdog (m_err).
// Latency: accept at T -> ISE ops in T+1..T+10, m_valid at T+11, plus one cycle per ISE stall.
// Backpressure: s_ready only in IDLE (no skid); result and m_err held in DONE until m_ready.
module ascon_ise_seq #(
   parameter int WAIT_MAX = 16
) (
   input  logic           ise_clk,
   input  logic           ise_rst,
   ascon_ise_seq_if.slave io
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t       st;
   logic [319:0] in_buf;
   logic [3:0]   cnt;
   logic [3:0]   cnt_nxt;

   assign cnt_nxt   = cnt + 4'd1;
   assign io.ise_fn = 5'b00001;

   if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_wait_max_range
      $error("ascon_ise_seq: WAIT_MAX must lie in 1..255");
   end

`ifdef ASCON_SEQ_WDOG_EN
   localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);
   logic [7:0] stall_cnt;
`else
   assign io.m_err = 1'b0;
`endif

   // Op c targets word c>>1, half c[0]; its 32-bit slot in m_state therefore starts at bit 32*c.
   always_ff @(posedge ise_clk) begin
      if (ise_rst) begin
         st         <= IDLE;
         in_buf     <= '0;
         cnt        <= '0;
         io.s_ready <= 1'b1;
         io.m_valid <= 1'b0;
         io.m_state <= '0;
         io.ise_val <= 1'b0;
         io.ise_imm <= '0;
         io.ise_in1 <= '0;
         io.ise_in2 <= '0;
`ifdef ASCON_SEQ_WDOG_EN
         io.m_err   <= 1'b0;
         stall_cnt  <= '0;
`endif
      end else begin
         case (st)
            IDLE: begin
               if (io.s_valid) begin
                  in_buf     <= io.s_state;
                  cnt        <= '0;
                  io.s_ready <= 1'b0;
                  io.ise_val <= 1'b1;
                  io.ise_imm <= '0;
                  io.ise_in1 <= io.s_state[31:0];
                  io.ise_in2 <= io.s_state[63:32];
                  st         <= ISSUE;
`ifdef ASCON_SEQ_WDOG_EN
                  io.m_err   <= 1'b0;
                  stall_cnt  <= '0;
`endif
               end
            end
            ISSUE: begin
               if (io.ise_oval) begin
                  io.m_state[{cnt, 5'd0} +: 32] <= io.ise_out;
`ifdef ASCON_SEQ_WDOG_EN
                  stall_cnt <= '0;
`endif
                  if (cnt == 4'd9) begin
                     io.ise_val <= 1'b0;
                     io.m_valid <= 1'b1;
                     st         <= DONE;
                  end else begin
                     // Operands always come from the captured buffer, never from partial results.
                     cnt        <= cnt_nxt;
                     io.ise_imm <= {1'b0, cnt_nxt[0], 2'b00, cnt_nxt[3:1]};
                     io.ise_in1 <= in_buf[{cnt_nxt[3:1], 6'd0} +: 32];
                     io.ise_in2 <= in_buf[{cnt_nxt[3:1], 6'd32} +: 32];
                  end
               end
`ifdef ASCON_SEQ_WDOG_EN
               else if (stall_cnt == WAIT_LIM) begin
                  io.ise_val <= 1'b0;
                  io.m_valid <= 1'b1;
                  io.m_err   <= 1'b1;
                  st         <= DONE;
               end else if (stall_cnt != 8'hff) begin
                  stall_cnt <= stall_cnt + 8'd1;
               end
`endif
            end
            DONE: begin
               if (io.m_ready) begin
                  io.m_valid <= 1'b0;
                  io.s_ready <= 1'b1;
                  st         <= IDLE;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ascon_ise_seq.sv
// Bench for ascon_ise_seq: behavioural ISE sigma model, vector table, random states with random ISE stalls,
// backpressure, mid-operation reset and the stuck-ISE case (watchdog abort when ASCON_SEQ_WDOG_EN is defined).
module tb_ascon_ise_seq;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ascon_ise_seq_if bus ();

   ascon_ise_seq #(.WAIT_MAX(16)) dut (
      .ise_clk (clk),
      .ise_rst (rst),
      .io      (bus.slave)
   );

   typedef struct {
      logic [319:0] st;
      logic [319:0] exp;
   } vec_t;

   // Ascon linear layer: x_i ^= (x_i >>> r0_i) ^ (x_i >>> r1_i)
   function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
      return (x >> r) | (x << (64 - r));
   endfunction

   function automatic logic [63:0] sigma64(input int i, input logic [63:0] x);
      int a, b;
      case (i)
         0: begin a = 19; b = 28; end
         1: begin a = 61; b = 39; end
         2: begin a = 1;  b = 6;  end
         3: begin a = 10; b = 17; end
         4: begin a = 7;  b = 41; end
         default: begin a = 0; b = 0; end
      endcase
      return x ^ rotr(x, a) ^ rotr(x, b);
   endfunction

   function automatic logic [319:0] ref_lin(input logic [319:0] s);
      logic [319:0] r;
      for (int w = 0; w < 5; w++) r[64*w +: 64] = sigma64(w, s[64*w +: 64]);
      return r;
   endfunction

   function automatic logic [31:0] sigma_half(input logic [6:0] imm, input logic [31:0] lo, input logic [31:0] hi);
      logic [63:0] y;
      y = sigma64(int'(imm[4:0]), {hi, lo});
      return imm[5] ? y[63:32] : y[31:0];
   endfunction

   function automatic logic [319:0] rand_state();
      logic [319:0] s;
      for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
      return s;
   endfunction

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // ISE model: 0 = answer at once, 1 = random 0..3 stall cycles per op, 2 = never answer, 3 = stray oval
   int   ise_mode = 0;
   logic ise_go = 1'b1;
   int   stall_left = 0;
   int   stall_cycles = 0;

   always_comb begin
      bus.ise_out  = sigma_half(bus.ise_imm, bus.ise_in1, bus.ise_in2);
      bus.ise_oval = 1'b0;
      case (ise_mode)
         0: bus.ise_oval = bus.ise_val;
         1: bus.ise_oval = bus.ise_val && ise_go;
         3: begin bus.ise_oval = 1'b1; bus.ise_out = 32'hdead_beef; end
         default: bus.ise_oval = 1'b0;
      endcase
   end

   always @(posedge clk) begin
      #1;
      if (bus.ise_val && stall_left > 0) begin
         ise_go = 1'b0;
         stall_left--;
      end else begin
         ise_go = 1'b1;
      end
   end

   logic [6:0]  log_imm[$];
   logic [31:0] log_in1[$];
   logic [31:0] log_in2[$];
   logic        prev_stall = 1'b0;
   logic [70:0] prev_req;

   always @(negedge clk) begin
      if (bus.ise_val && prev_stall)
         check("req_stable_in_stall", {bus.ise_imm, bus.ise_in1, bus.ise_in2}, prev_req);
      prev_stall = bus.ise_val && !bus.ise_oval;
      prev_req   = {bus.ise_imm, bus.ise_in1, bus.ise_in2};
      if (prev_stall) stall_cycles++;
      if (bus.ise_val && bus.ise_oval) begin
         log_imm.push_back(bus.ise_imm);
         log_in1.push_back(bus.ise_in1);
         log_in2.push_back(bus.ise_in2);
         stall_left = $urandom_range(0, 3);
      end
   end

   task automatic send(input logic [319:0] st, output int t_acc);
      bit ok;
      ok = 1'b0;
      t_acc = cyc;
      bus.s_state = st;
      bus.s_valid = 1'b1;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (bus.s_ready) begin
            ok = 1'b1;
            t_acc = cyc;
         end
      end
      check("accept", ok, 1);
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_state = '0;
   endtask

   task automatic wait_done(input int limit, output int t_done, output bit seen);
      seen = 1'b0;
      t_done = cyc;
      for (int k = 0; k < limit && !seen; k++) begin
         @(negedge clk);
         if (bus.m_valid) begin
            seen = 1'b1;
            t_done = cyc;
         end
      end
   endtask

   task automatic run_one(input string tag, input logic [319:0] st, input logic [319:0] exp);
      int ta, td;
      bit seen;
      log_imm.delete();
      log_in1.delete();
      log_in2.delete();
      stall_cycles = 0;
      send(st, ta);
      wait_done(300, td, seen);
      check($sformatf("%s_done", tag), seen, 1);
      if (seen) begin
         check($sformatf("%s_state", tag), bus.m_state, exp);
         check($sformatf("%s_err", tag), bus.m_err, 0);
         check($sformatf("%s_latency", tag), td - ta, 11 + stall_cycles);
         check($sformatf("%s_nreq", tag), log_imm.size(), 10);
         for (int c = 0; c < 10; c++) begin
            if (c < log_imm.size()) begin
               automatic logic [6:0] e_imm = {1'b0, 1'(c & 1), 5'(c >> 1)};
               check($sformatf("%s_imm%0d", tag, c), log_imm[c], e_imm);
               check($sformatf("%s_in1_%0d", tag, c), log_in1[c], st[64*(c/2) +: 32]);
               check($sformatf("%s_in2_%0d", tag, c), log_in2[c], st[64*(c/2) + 32 +: 32]);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not end, cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      vec_t         vecs[8];
      logic [319:0] s, last_exp;
      int           ta, td, n_mv;
      bit           seen, found;

      vecs[0].st  = {256'd0, 64'h0123_4567_89ab_cdef};
      vecs[0].exp = {256'd0, 64'he222_7bb3_f333_6aa2};
      vecs[1].st  = {320{1'b1}};
      vecs[1].exp = {320{1'b1}};
      vecs[2].st  = '0;
      vecs[2].exp = '0;
      vecs[3].st  = {128'd0, 64'h1, 128'd0};
      vecs[3].exp = {128'd0, 64'h8400_0000_0000_0001, 128'd0};
      vecs[4].st  = {64'h1, 256'd0};
      vecs[4].exp = {64'h0200_0000_0080_0001, 256'd0};
      vecs[5].st  = {64'd0, 64'h1, 64'd0, 64'h1, 64'd0};
      vecs[5].exp = {64'd0, 64'h0040_8000_0000_0001, 64'd0, 64'h0000_0000_0200_0009, 64'd0};
      for (int k = 6; k < 8; k++) begin
         vecs[k].st  = rand_state();
         vecs[k].exp = ref_lin(vecs[k].st);
      end

      rst         = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_state = '0;
      bus.m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_s_ready", bus.s_ready, 1);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_ise_val", bus.ise_val, 0);
      check("rst_m_err", bus.m_err, 0);
      check("rst_m_state", bus.m_state, 0);
      check("rst_ise_req", {bus.ise_imm, bus.ise_in1, bus.ise_in2}, 0);
      check("ise_fn", bus.ise_fn, 5'b00001);

      // A responding ISE outside ISSUE must not disturb the idle sequencer.
      ise_mode = 3;
      repeat (3) begin
         @(negedge clk);
         check("stray_oval_idle", {bus.m_valid, bus.ise_val, bus.s_ready}, 3'b001);
      end
      @(posedge clk);
      #1;
      ise_mode = 0;

      for (int pass = 0; pass < 2; pass++) begin
         ise_mode = pass;
         for (int k = 0; k < 8; k++) run_one($sformatf("vec%0d_p%0d", k, pass), vecs[k].st, vecs[k].exp);
      end

      ise_mode = 1;
      for (int k = 0; k < 12; k++) begin
         s = rand_state();
         run_one($sformatf("rand%0d", k), s, ref_lin(s));
      end

      // Backpressure: result must hold while m_ready is low, and the next state must wait for the handshake.
      ise_mode = 0;
      bus.m_ready = 1'b0;
      s = rand_state();
      send(s, ta);
      wait_done(50, td, seen);
      check("bp_done", seen, 1);
      check("bp_latency", td - ta, 11);
      bus.s_state = rand_state();
      bus.s_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("bp_hold", {bus.m_valid, bus.s_ready, bus.m_state}, {2'b10, ref_lin(s)});
      end
      @(posedge clk);
      #1;
      bus.m_ready = 1'b1;
      @(negedge clk);
      check("bp_handshake_cycle", {bus.m_valid, bus.s_ready}, 2'b10);
      @(negedge clk);
      check("bp_idle_after", {bus.m_valid, bus.s_ready}, 2'b01);
      ta = cyc;
      s = bus.s_state;
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      wait_done(50, td, seen);
      check("bp_second_done", seen, 1);
      check("bp_second_latency", td - ta, 11);
      check("bp_second_state", bus.m_state, ref_lin(s));
      @(posedge clk);
      #1;

      // Reset while op c=4 (sigma_lo of x2) is on the bus.
      s = rand_state();
      send(s, ta);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (bus.ise_val && bus.ise_imm == 7'h02) found = 1'b1;
      end
      check("midrst_reach_c4", found, 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_idle", {bus.ise_val, bus.m_valid, bus.s_ready}, 3'b001);
      rst = 1'b0;
      n_mv = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.m_valid) n_mv++;
      end
      check("midrst_no_m_valid", n_mv, 0);
      @(posedge clk);
      #1;
      s = rand_state();
      last_exp = ref_lin(s);
      run_one("after_rst", s, last_exp);

      ise_mode = 2;
`ifdef ASCON_SEQ_WDOG_EN
      send(rand_state(), ta);
      wait_done(60, td, seen);
      check("wdog_done", seen, 1);
      check("wdog_latency", td - ta, 18);
      check("wdog_err", bus.m_err, 1);
      check("wdog_ise_val", bus.ise_val, 0);
      check("wdog_state_kept", bus.m_state, last_exp);
      @(posedge clk);
      #1;
      ise_mode = 0;
      s = rand_state();
      run_one("wdog_recover", s, ref_lin(s));
`else
      send(rand_state(), ta);
      n_mv = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus.m_valid) n_mv++;
      end
      check("stuck_no_m_valid", n_mv, 0);
      check("stuck_still_issuing", {bus.ise_val, bus.s_ready, bus.m_err}, 3'b100);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      ise_mode = 0;
      s = rand_state();
      run_one("stuck_recover", s, ref_lin(s));
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ascon_ise_seq.md
Name: ascon_ise_seq

Overview:
- Sequencer that applies the Ascon linear diffusion layer to a full 320-bit state (x0..x4) through the shared 32-bit Ascon ISE datapath.
- Issues 10 sigma operations, one per word half, on the ISE request bus. A sigma_lo and a sigma_hi are issued for each of the five 64-bit words. Results are collected into a 320-bit output.
- Sits between an accelerator front-end (valid/ready) and the ISE ALU port (ise_fn/ise_imm/ise_in1/ise_in2/ise_val -> ise_oval/ise_out).

Parameters:
- WAIT_MAX, 16, number of consecutive stalled cycles (ise_val=1, ise_oval=0) before watchdog abort; used only when ASCON_SEQ_WDOG_EN is defined; legal range 1..255.

Ports:
- ise_clk  in  1  clock; single clock domain.
- ise_rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input state valid.
- s_ready  out  1  sequencer can accept a state.
- s_state  in  320  input state; x_i = s_state[64*i+:64]; lo half = [64*i+:32], hi half = [64*i+32+:32].
- m_valid  out  1  result valid.
- m_ready  in  1  consumer accepts result.
- m_state  out  320  diffused state, same packing as s_state.
- m_err  out  1  result aborted by watchdog; qualified by m_valid.
- ise_fn  out  5  ISE function; constant 5'b00001 (CUSTOM_1 in bits [1:0]).
- ise_imm  out  7  funct: [6:5]=2'b00 for sigma_lo, 2'b01 for sigma_hi; [4:0]=word index i (0..4).
- ise_in1  out  32  lo half of x_i.
- ise_in2  out  32  hi half of x_i.
- ise_val  out  1  ISE request valid.
- ise_oval  in  1  ISE result valid.
- ise_out  in  32  ISE result.

Behaviour:
- Reset: all state synchronous to ise_clk, cleared when ise_rst=1 at a rising edge. After reset: state=IDLE, s_ready=1, m_valid=0, m_err=0, ise_val=0, ise_imm=0, ise_in1=0, ise_in2=0, m_state=0, op counter=0, stall counter=0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE: s_ready=1. On s_valid&&s_ready, capture s_state into the input buffer, clear op counter and m_err, go to ISSUE. s_ready=0 in every other state; there is no input skid.
- ISSUE:
  - Op counter c runs 0..9; word i=c>>1; half=c[0] (0=lo, 1=hi).
  - Outputs: ise_val=1, ise_imm={1'b0,half,i[4:0]}, ise_in1/ise_in2 = input-buffer lo/hi of x_i.
  - Operands always come from the captured input buffer, never from partial results, so sigma_hi sees the same x_i as sigma_lo.
  - When ise_oval=1 in the same cycle: write ise_out into m_state[64*i+32*half+:32], clear the stall counter, increment c. If c==9, go to DONE.
  - When ise_oval=0: hold all request outputs stable and increment the stall counter (saturating).
- DONE: m_valid=1 with m_state and m_err held stable until m_ready. On m_valid&&m_ready go to IDLE. The next s_valid is accepted no earlier than the following cycle.
- Latency: with ise_oval tied to ise_val, acceptance at cycle T gives ISSUE in cycles T+1..T+10 and m_valid in T+11. Each stall cycle adds one.
- Throughput: one state per 12 cycles minimum, with m_ready held high.
- ise_val is never asserted outside ISSUE. ise_oval or ise_out arriving outside ISSUE is ignored.
- Reset mid-operation returns to IDLE with no m_valid. The partial result is not flushed to m_state.
- m_state outside DONE is undefined to consumers but deterministic (holds its last writes).

Optional Feature:
- Macro: ASCON_SEQ_WDOG_EN.
- Defined:
  - In ISSUE, if the stall counter reaches WAIT_MAX, go to DONE with m_err=1.
  - Unwritten halves of m_state keep their prior contents.
  - ise_val drops in the cycle after the abort.
- Undefined:
  - No stall counter.
  - m_err tied to 0.
  - ISSUE waits indefinitely for ise_oval.

Test Plan:
- Reset then idle: ise_rst high 2 cycles -> s_ready=1, m_valid=0, ise_val=0, m_err=0.
- Single state, ise_oval=ise_val, ISE model = Ascon sigma: x0=0x0123456789abcdef, others 0 -> exactly 10 requests in order imm=0x00,0x20,0x01,0x21,...,0x04,0x24; m_valid at T+11; m_state[63:0] equals the reference x0 ^ (x0>>>19) ^ (x0>>>28); other words 0.
- Random stalls (ise_oval low 0-3 cycles per op) -> ise_imm/ise_in1/ise_in2 stable while stalled; result identical to the no-stall run; latency = 11 + total stalls.
- Backpressure: m_ready low 5 cycles -> m_valid and m_state stable; s_ready=0 throughout; second state accepted only after the handshake.
- Reset asserted at op c=4 -> next cycle IDLE, ise_val=0, no m_valid; a following state completes correctly.
- ASCON_SEQ_WDOG_EN, WAIT_MAX=16, ise_oval stuck 0 -> m_valid with m_err=1 after 1+16 ISSUE cycles; with the macro undefined, m_valid stays 0 for 100 cycles.
